sipo_rx: RTL

Serial-in, parallel-out frame receiver: the receive end of the design's 75-bit serial word link. It samples one bit per enabled cycle, MSB first, using a start-of-frame strobe for alignment. It assembles each complete word into a held output register and presents it with a valid/ready handshake. It also tracks which of the 4 matrix rows the word belongs to and flags framing and overrun errors.

---
 rtl/sipo_rx_pkg.sv | 19 +
 rtl/sipo_shift_core.sv | 44 ++++
 rtl/sipo_rx.sv | 90 +++++++++
 3 files changed

// File: rtl/sipo_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_rx_pkg
// Description : Shared constants and FSM state type for the SIPO frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_rx_pkg;

    localparam int FRAME_W  = 75;
    localparam int NUM_ROWS = 4;
    localparam int ROW_W    = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sipo_shift_core.sv
`default_nettype none
// ============================================================================
// Module      : sipo_shift_core
// Description : MSB-first shift register and bit counter; flags the final bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift_core
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH = FRAME_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             shift,
    input  logic             din,
    output logic [WIDTH-1:0] word,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Only WIDTH-1 bits are stored; the incoming bit completes the word.
    logic [WIDTH-2:0] r_shift_reg;
    logic [CNT_W-1:0] r_cnt;

    assign word = {r_shift_reg, din};
    assign done = shift && (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_reg <= '0;
            r_cnt       <= '0;
        end else if (start) begin
            r_shift_reg <= word[WIDTH-2:0];
            r_cnt       <= CNT_W'(1);
        end else if (shift) begin
            r_shift_reg <= word[WIDTH-2:0];
            r_cnt       <= done ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
// Module      : sipo_rx
// Description : Serial-in parallel-out frame receiver with valid/ready output,
//               row tracking, framing-error and overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH = FRAME_W,
    parameter int ROWS  = NUM_ROWS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [ROW_W-1:0] row,
    output logic             frame_err,
    output logic             overrun
);

    state_t           r_state;
    logic             w_start;
    logic             w_shift;
    logic             w_done;
    logic [WIDTH-1:0] w_word;
    logic [ROW_W-1:0] w_row_next;

    // A strobed sof always restarts the frame, whatever the current state.
    assign w_start    = en & sof;
    assign w_shift    = en & ~sof & (r_state == SHIFT);
    assign w_row_next = ((row == ROW_W'(ROWS)) || (row == '0)) ? ROW_W'(1)
                                                                : row + ROW_W'(1);

    sipo_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .shift (w_shift),
        .din   (din),
        .word  (w_word),
        .done  (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            row        <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_start) r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_start)     frame_err <= 1'b1;
                    else if (w_done) r_state   <= IDLE;
                end
            endcase

            if (w_done) begin
                // Load only if the held word is gone or leaves this same cycle.
                if (!dout_valid || dout_ready) begin
                    dout       <= w_word;
                    dout_valid <= 1'b1;
                    row        <= w_row_next;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
